bus_arbiter_mux: RTL and testbench
==================================

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of each source and of the bus.
REQ-002 The block SHALL have parameter NSRC, default 10, giving the number of sources; legal range 2..32.
REQ-003 The block SHALL have parameter IDLE_VAL, default 16'h55AA, truncated or zero-extended to WIDTH, giving the bus value driven when no transfer is valid.
REQ-004 The block SHALL have port Clock, input, width 1: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port Reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port Req, input, width NSRC: bit i set means source i requests the bus.
REQ-007 The block SHALL have port Din, input, width NSRC*WIDTH: source i data at bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port Lock, input, width 1: when set at transfer completion, the current owner keeps priority.
REQ-009 The block SHALL have port Ready, input, width 1: the consumer accepts BusWires this cycle.
REQ-010 The block SHALL have port Grant, output, width NSRC: one-hot current owner, or all zeros.
REQ-011 The block SHALL have port BusWires, output, width WIDTH: registered bus data.
REQ-012 The block SHALL have port BusValid, output, width 1: BusWires holds a valid word.

Function
REQ-013 The block SHALL implement two states: IDLE (BusValid=0) and BUSY (BusValid=1).
REQ-014 In IDLE, any Req bit set SHALL move the block to BUSY on the next edge, registering Grant, BusWires=Din[winner] and BusValid=1.
REQ-015 In BUSY, BusWires, Grant and BusValid SHALL hold stable while Ready=0, regardless of Req or Din changes.
REQ-016 In BUSY with Ready=1 (a transfer), the block SHALL arbitrate in the same cycle: if any Req bit is set it stays in BUSY with the new winner on the next edge (zero-bubble back-to-back); otherwise it returns to IDLE.
REQ-017 Arbitration SHALL be round-robin: the winner is the lowest index at or above pointer P, with wrap-around, among set Req bits.
REQ-018 After each transfer with Lock=0, P SHALL become (owner+1) mod NSRC; with Lock=1, P SHALL become owner, so that the owner wins again if it still requests.
REQ-019 P SHALL change only on a transfer; a Ready=1 in IDLE has no effect.
REQ-020 Data SHALL be sampled from Din on the grant edge only; a source dropping Req while it is owner SHALL NOT cancel the pending word.
REQ-021 In IDLE, the outputs SHALL be Grant=0, BusValid=0 and BusWires=IDLE_VAL.
REQ-022 Grant SHALL always be zero or one-hot, and nonzero exactly when BusValid=1.
REQ-023 Latency from Req rising in IDLE to BusValid SHALL be exactly 1 cycle.

Reset
REQ-024 Reset=1 at a rising edge SHALL force state IDLE, Grant=0, BusValid=0, BusWires=IDLE_VAL and P=0, overriding all other inputs.
REQ-025 Reset asserted during BUSY SHALL discard the pending word with no transfer counted and no change to P other than the reset to 0.
REQ-026 On the first edge after Reset deasserts, the block SHALL arbitrate normally from P=0.

Verification
REQ-027 Reset, then Req=0 for 3 cycles -> BusWires=16'h55AA, BusValid=0, Grant=0 every cycle.
REQ-028 Req=10'b00_0000_1001, Din[0]=16'h1111, Din[3]=16'h3333, Ready=1, Lock=0 -> cycle 1: Grant=bit0, BusWires=16'h1111; cycle 2: Grant=bit3, BusWires=16'h3333; cycle 3: Grant=bit0 again.
REQ-029 Grant to source 5 with Din[5]=16'hABCD, Ready=0 for 4 cycles while Din[5] changes to 16'h0000 and Req[5] drops -> BusWires stays 16'hABCD with BusValid=1 until Ready=1, then IDLE.
REQ-030 Req=all ones, Lock=1, Ready=1 -> source 0 wins 5 consecutive transfers; Lock=0 on the 6th transfer -> the next winner is source 1.
REQ-031 Req[9]=1 only, P=9, then Req=bit9|bit2 after the transfer -> wrap-around: source 2 wins before source 9 wins again.
REQ-032 Reset asserted while BusValid=1, Ready=0 -> next edge: BusValid=0, BusWires=16'h55AA; with Req=all ones after release -> source 0 wins.

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// ============================================================================
// Module   : bus_arbiter_mux
// Purpose  : Round-robin arbiter that multiplexes NSRC data sources onto one
//            registered bus with a valid/ready handshake toward the consumer.
//            A transfer (BusValid & Ready) re-arbitrates in the same cycle, so
//            back-to-back grants carry no bubble. Lock keeps the current owner
//            at the head of the round-robin order.
// Ports    : Clock    - single clock, rising edge
//            Reset    - synchronous, active-high
//            Req      - [NSRC-1:0] per-source bus request
//            Din      - [NSRC*WIDTH-1:0] source i data at [i*WIDTH +: WIDTH]
//            Lock     - owner keeps priority when set at transfer completion
//            Ready    - consumer accepts BusWires this cycle
//            Grant    - [NSRC-1:0] one-hot current owner, or zero
//            BusWires - [WIDTH-1:0] registered bus data
//            BusValid - BusWires holds a valid word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_mux #(
  parameter int                WIDTH    = 16,
  parameter int                NSRC     = 10,
  parameter logic [WIDTH-1:0]  IDLE_VAL = WIDTH'(16'h55AA)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NSRC-1:0]        Req,
  input  logic [NSRC*WIDTH-1:0]  Din,
  input  logic                   Lock,
  input  logic                   Ready,
  output logic [NSRC-1:0]        Grant,
  output logic [WIDTH-1:0]       BusWires,
  output logic                   BusValid
);

  localparam int PW = $clog2(NSRC);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]        state, next_state;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [PW-1:0]     owner, owner_nxt;
  logic [NSRC-1:0]   grant_r, grant_nxt;
  logic [WIDTH-1:0]  bus_r, bus_nxt;

  logic              any_req, xfer, load, found;
  logic [PW-1:0]     rr_ptr, arb_ptr, winner;
  logic [PW:0]       cand;
  logic [NSRC-1:0]   win_onehot;
  logic [WIDTH-1:0]  win_data;

  assign any_req = |Req;
  assign xfer    = (state == S_BUSY) && Ready;
  assign load    = any_req && ((state == S_IDLE) || Ready);

  // Pointer value that takes effect once the current transfer completes.
  assign rr_ptr  = Lock ? owner
                 : ((owner == PW'(NSRC - 1)) ? '0 : owner + 1'b1);

  // A completing transfer arbitrates against the post-transfer pointer so
  // the zero-bubble regrant already honours the round-robin/lock update.
  assign arb_ptr = xfer ? rr_ptr : ptr;

  // Lowest requesting index at or above arb_ptr, with wrap-around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = {1'b0, arb_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NSRC)) begin
        cand = cand - (PW+1)'(NSRC);
      end
      if (!found && Req[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_data   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (winner == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_data      = Din[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register (also holds the registered bus outputs and pointer).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      owner   <= '0;
      grant_r <= '0;
      bus_r   <= IDLE_VAL;
    end else begin
      state   <= next_state;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      grant_r <= grant_nxt;
      bus_r   <= bus_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (any_req) next_state = S_BUSY;
      S_BUSY:  if (Ready && !any_req) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output / datapath logic. While BUSY without Ready everything holds, so
  // Din or Req changes cannot disturb the pending word.
  always_comb begin
    grant_nxt = grant_r;
    bus_nxt   = bus_r;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    if (xfer) begin
      ptr_nxt   = rr_ptr;
      grant_nxt = '0;
      bus_nxt   = IDLE_VAL;
    end
    if (load) begin
      grant_nxt = win_onehot;
      bus_nxt   = win_data;
      owner_nxt = winner;
    end
  end

  assign Grant    = grant_r;
  assign BusWires = bus_r;
  assign BusValid = (state == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_mux.sv
// ============================================================================
// Module   : tb_bus_arbiter_mux
// Purpose  : Self-checking bench for bus_arbiter_mux. Stimulus pushes the
//            expected {grant, data} of each transfer into a queue; a monitor
//            pops and compares on every cycle where BusValid & Ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_mux;

  localparam int WIDTH = 16;
  localparam int NSRC  = 10;

  logic                  Clock;
  logic                  Reset;
  logic [NSRC-1:0]       Req;
  logic [NSRC*WIDTH-1:0] Din;
  logic                  Lock;
  logic                  Ready;
  logic [NSRC-1:0]       Grant;
  logic [WIDTH-1:0]      BusWires;
  logic                  BusValid;

  logic [WIDTH-1:0]      din_arr [NSRC];
  logic [25:0]           exp_q [$];
  int                    checks;
  int                    failures;

  bus_arbiter_mux #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .IDLE_VAL (16'h55AA)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Req      (Req),
    .Din      (Din),
    .Lock     (Lock),
    .Ready    (Ready),
    .Grant    (Grant),
    .BusWires (BusWires),
    .BusValid (BusValid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_din();
    for (int i = 0; i < NSRC; i++) Din[i*WIDTH +: WIDTH] = din_arr[i];
  endtask

  task automatic push(input int src, input logic [WIDTH-1:0] d);
    logic [NSRC-1:0] g;
    g = '0;
    g[src] = 1'b1;
    exp_q.push_back({g, d});
  endtask

  // {BusValid, Grant, BusWires} in one word.
  task automatic check_bus(input string name, input logic v, input logic [NSRC-1:0] g,
                           input logic [WIDTH-1:0] d);
    check(name, 32'({BusValid, Grant, BusWires}), 32'({v, g, d}));
  endtask

  initial begin
    logic [25:0] e;
    checks   = 0;
    failures = 0;
    Reset = 1'b1; Req = '0; Din = '0; Lock = 1'b0; Ready = 1'b0;
    for (int i = 0; i < NSRC; i++) din_arr[i] = '0;

    fork
      forever begin
        @(negedge Clock);
        if (!Reset && BusValid && Ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", 32'(Grant), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("xfer_grant", 32'(Grant), 32'(e[25:16]));
            check("xfer_data", 32'(BusWires), 32'(e[15:0]));
          end
        end
      end
    join_none

    // Reset state
    tick(); tick();
    check_bus("reset_state", 1'b0, '0, 16'h55AA);
    Reset = 1'b0;

    // Idle with no requests; Ready in IDLE must not move the pointer
    Ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_bus("idle_noreq", 1'b0, '0, 16'h55AA);
    end

    // Back-to-back round robin between sources 0 and 3
    din_arr[0] = 16'h1111; din_arr[3] = 16'h3333; drive_din();
    Req = 10'b00_0000_1001; Lock = 1'b0;
    push(0, 16'h1111); push(3, 16'h3333); push(0, 16'h1111);
    tick();
    check_bus("latency_1", 1'b1, 10'b00_0000_0001, 16'h1111);
    tick(); tick();
    Req = '0;
    tick();
    check_bus("rr_to_idle", 1'b0, '0, 16'h55AA);

    // Hold while Ready=0; dropped Req and changed Din must not disturb word
    Ready = 1'b0;
    din_arr[5] = 16'hABCD; drive_din();
    Req = 10'b00_0010_0000;
    push(5, 16'hABCD);
    tick();
    check_bus("hold_grant", 1'b1, 10'b00_0010_0000, 16'hABCD);
    din_arr[5] = 16'h0000; drive_din();
    Req = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_bus("hold_stable", 1'b1, 10'b00_0010_0000, 16'hABCD);
    end
    Ready = 1'b1;
    tick();
    check_bus("hold_release", 1'b0, '0, 16'h55AA);

    // Lock: source 0 keeps winning, unlock hands over to source 1
    Ready = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < NSRC; i++) din_arr[i] = 16'hA000 | 16'(i);
    drive_din();
    Req = '1; Lock = 1'b1; Ready = 1'b1;
    for (int c = 0; c < 6; c++) push(0, 16'hA000);
    push(1, 16'hA001);
    for (int c = 0; c < 6; c++) tick();
    Lock = 1'b0;
    tick();
    check_bus("lock_handover", 1'b1, 10'b00_0000_0010, 16'hA001);
    Req = '0;
    tick();
    check_bus("lock_idle", 1'b0, '0, 16'h55AA);

    // Wrap-around: 9 -> 2 -> 9
    din_arr[9] = 16'h9999; din_arr[2] = 16'h2222; drive_din();
    Req = 10'b10_0000_0000;
    push(9, 16'h9999);
    tick();
    Req = 10'b10_0000_0100;
    push(2, 16'h2222); push(9, 16'h9999);
    tick();
    check_bus("wrap_to_2", 1'b1, 10'b00_0000_0100, 16'h2222);
    tick();
    Req = '0;
    tick();
    check_bus("wrap_idle", 1'b0, '0, 16'h55AA);

    // Reset while BUSY discards the word; arbitration restarts from 0
    Ready = 1'b0;
    din_arr[4] = 16'h4444; drive_din();
    Req = 10'b00_0001_0000;
    tick();
    check_bus("pre_reset_busy", 1'b1, 10'b00_0001_0000, 16'h4444);
    Reset = 1'b1;
    tick();
    check_bus("reset_in_busy", 1'b0, '0, 16'h55AA);
    Reset = 1'b0;
    Req = '1; Ready = 1'b1;
    push(0, 16'hA000);
    tick();
    check_bus("post_reset_win0", 1'b1, 10'b00_0000_0001, 16'hA000);
    Req = '0;
    tick();
    check_bus("final_idle", 1'b0, '0, 16'h55AA);
    tick();
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
